// File: rtl/i2c_pkg.sv
// ----------------------------------------------------------------------------
// i2c_pkg
// Shared types and constants for the single-byte I2C master engine.
//   i2c_state_t   : transaction state encoding
//   sclRelease()  : SCL open-drain control for a given state/quarter
//   sdaRelease()  : SDA open-drain control for a given state/quarter
// ----------------------------------------------------------------------------
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_DATA,
      ST_DATA_ACK,
      ST_STOP
   } i2c_state_t;

   localparam int   QUARTERS_PER_BIT = 4;
   localparam int   BITS_PER_BYTE    = 8;
   localparam logic I2C_RW_WRITE     = 1'b0;
   localparam logic I2C_RW_READ      = 1'b1;

   // 1 = release SCL. START pulls SCL low only in its last quarter, bit slots
   // release it for the upper half, STOP pulls it low only in its first quarter.
   function automatic logic sclRelease(input i2c_state_t st, input logic [1:0] qtr);
      logic rel;
      rel = 1'b1;
      case (st)
         ST_START:                                   rel = (qtr != 2'd3);
         ST_ADDR, ST_ADDR_ACK, ST_DATA, ST_DATA_ACK: rel = qtr[1];
         ST_STOP:                                    rel = (qtr != 2'd0);
         default:                                    rel = 1'b1;
      endcase
      return rel;
   endfunction

   // 1 = release SDA. Acknowledge slots and read data leave the line to the
   // slave; the master also leaves it released for the read-data ACK slot,
   // which is the NACK that ends a single-byte read.
   function automatic logic sdaRelease(input i2c_state_t st, input logic [1:0] qtr,
                                       input logic txMsb, input logic isRead);
      logic rel;
      rel = 1'b1;
      case (st)
         ST_START: rel = ~qtr[1];
         ST_ADDR:  rel = txMsb;
         ST_DATA:  rel = isRead | txMsb;
         ST_STOP:  rel = qtr[1];
         default:  rel = 1'b1;
      endcase
      return rel;
   endfunction

endpackage

// File: rtl/i2c_sync.sv
// ----------------------------------------------------------------------------
// i2c_sync
// Two-flop synchronizer for one bus line read back from the open-drain bus.
// Resets to 1 (idle bus level).
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   d_i    : asynchronous line input
//   q_o    : synchronized line
// ----------------------------------------------------------------------------
module i2c_sync (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Plain double-register; first stage may go metastable, second is used.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/i2c_master.sv
// ----------------------------------------------------------------------------
// i2c_master
// Single-byte I2C master: START, address + R/W, one data byte, STOP.
// Supports slave clock stretching and reports address / write-data NACK.
//   I_CLK, I_NRESET        : clock, asynchronous active-low reset
//   I_START                : command strobe (taken only when idle)
//   I_RW, I_ADDR, I_WDATA  : command fields (0 = write, 1 = read)
//   I_SCL, I_SDA           : resolved bus lines (asynchronous)
//   O_SCL_T, O_SDA_T       : open-drain controls, 1 = release, 0 = pull low
//   O_BUSY, O_DONE         : transaction in progress / one-cycle end pulse
//   O_RDATA, O_NACK        : read byte and NACK flag, valid from O_DONE
// ----------------------------------------------------------------------------
module i2c_master
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = 125
) (
   input  logic       I_CLK,
   input  logic       I_NRESET,
   input  logic       I_START,
   input  logic       I_RW,
   input  logic [6:0] I_ADDR,
   input  logic [7:0] I_WDATA,
   input  logic       I_SCL,
   input  logic       I_SDA,
   output logic       O_SCL_T,
   output logic       O_SDA_T,
   output logic       O_BUSY,
   output logic       O_DONE,
   output logic [7:0] O_RDATA,
   output logic       O_NACK
);

   localparam int             CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0]  DIV_LAST = CW'(CLK_DIV - 1);
   localparam logic [1:0]     QTR_LAST = 2'(QUARTERS_PER_BIT - 1);
   localparam logic [2:0]     BIT_LAST = 3'(BITS_PER_BYTE - 1);

   i2c_state_t    state_q,  state_d;
   logic [CW-1:0] divCnt_q, divCnt_d;
   logic [1:0]    qtr_q,    qtr_d;
   logic [2:0]    bitCnt_q, bitCnt_d;
   logic          rw_q,     rw_d;
   logic [7:0]    wdata_q,  wdata_d;
   logic [7:0]    txByte_q, txByte_d;
   logic [7:0]    rdata_q,  rdata_d;
   logic          nack_q,   nack_d;
   logic          busy_q,   busy_d;
   logic          done_q,   done_d;
   logic          sclT_q,   sclT_d;
   logic          sdaT_q,   sdaT_d;

   logic sclSync;
   logic sdaSync;
   logic bitPhase;
   logic stretchHold;
   logic sampleNow;
   logic phaseEnd;

   i2c_sync u_sclSync (.clk_i(I_CLK), .rst_ni(I_NRESET), .d_i(I_SCL), .q_o(sclSync));
   i2c_sync u_sdaSync (.clk_i(I_CLK), .rst_ni(I_NRESET), .d_i(I_SDA), .q_o(sdaSync));

   assign bitPhase = (state_q == ST_ADDR) || (state_q == ST_ADDR_ACK) ||
                     (state_q == ST_DATA) || (state_q == ST_DATA_ACK);

   // The quarter in which SCL was released may not end until the slave lets
   // SCL actually rise; the synchronizer lag is absorbed by the quarter length.
   assign stretchHold = !sclSync &&
                        ((bitPhase && (qtr_q == 2'd2)) ||
                         ((state_q == ST_STOP) && (qtr_q == 2'd1)));

   assign sampleNow = bitPhase && (qtr_q == QTR_LAST) && (divCnt_q == '0);

   // Next-state logic: quarter/bit timing, byte shifting and command sequencing.
   always_comb begin
      state_d  = state_q;
      divCnt_d = divCnt_q;
      qtr_d    = qtr_q;
      bitCnt_d = bitCnt_q;
      rw_d     = rw_q;
      wdata_d  = wdata_q;
      txByte_d = txByte_q;
      rdata_d  = rdata_q;
      nack_d   = nack_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      phaseEnd = 1'b0;

      if (state_q != ST_IDLE) begin
         if (divCnt_q == DIV_LAST) begin
            if (!stretchHold) begin
               divCnt_d = '0;
               qtr_d    = qtr_q + 2'd1;
               phaseEnd = (qtr_q == QTR_LAST);
            end
         end else begin
            divCnt_d = divCnt_q + 1'b1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (I_START) begin
               state_d  = ST_START;
               divCnt_d = '0;
               qtr_d    = 2'd0;
               bitCnt_d = 3'd0;
               rw_d     = I_RW;
               wdata_d  = I_WDATA;
               txByte_d = {I_ADDR, I_RW};
               nack_d   = 1'b0;
               busy_d   = 1'b1;
            end
         end
         ST_START: begin
            if (phaseEnd) begin
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (phaseEnd) begin
               txByte_d = {txByte_q[6:0], 1'b1};
               bitCnt_d = bitCnt_q + 3'd1;
               if (bitCnt_q == BIT_LAST) begin
                  state_d = ST_ADDR_ACK;
               end
            end
         end
         ST_ADDR_ACK: begin
            if (sampleNow && sdaSync) begin
               nack_d = 1'b1;
            end
            // The sample lands early in q3, so nack_q is settled by phase end.
            if (phaseEnd) begin
               if (nack_q) begin
                  state_d = ST_STOP;
               end else begin
                  state_d  = ST_DATA;
                  txByte_d = wdata_q;
               end
            end
         end
         ST_DATA: begin
            if (sampleNow && (rw_q == I2C_RW_READ)) begin
               rdata_d = {rdata_q[6:0], sdaSync};
            end
            if (phaseEnd) begin
               txByte_d = {txByte_q[6:0], 1'b1};
               bitCnt_d = bitCnt_q + 3'd1;
               if (bitCnt_q == BIT_LAST) begin
                  state_d = ST_DATA_ACK;
               end
            end
         end
         ST_DATA_ACK: begin
            if (sampleNow && (rw_q == I2C_RW_WRITE) && sdaSync) begin
               nack_d = 1'b1;
            end
            if (phaseEnd) begin
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (phaseEnd) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // SCL follows the upcoming quarter; SDA follows the current one, so SDA
      // always moves one cycle after SCL has gone low and never races it.
      sclT_d = sclRelease(state_d, qtr_d);
      sdaT_d = sdaRelease(state_q, qtr_q, txByte_q[7], rw_q);
   end

   // State and datapath registers; reset releases both bus lines at once.
   always_ff @(posedge I_CLK or negedge I_NRESET) begin
      if (!I_NRESET) begin
         state_q  <= ST_IDLE;
         divCnt_q <= '0;
         qtr_q    <= 2'd0;
         bitCnt_q <= 3'd0;
         rw_q     <= 1'b0;
         wdata_q  <= 8'h00;
         txByte_q <= 8'h00;
         rdata_q  <= 8'h00;
         nack_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         sclT_q   <= 1'b1;
         sdaT_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         divCnt_q <= divCnt_d;
         qtr_q    <= qtr_d;
         bitCnt_q <= bitCnt_d;
         rw_q     <= rw_d;
         wdata_q  <= wdata_d;
         txByte_q <= txByte_d;
         rdata_q  <= rdata_d;
         nack_q   <= nack_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         sclT_q   <= sclT_d;
         sdaT_q   <= sdaT_d;
      end
   end

   assign O_SCL_T = sclT_q;
   assign O_SDA_T = sdaT_q;
   assign O_BUSY  = busy_q;
   assign O_DONE  = done_q;
   assign O_RDATA = rdata_q;
   assign O_NACK  = nack_q;

endmodule

// File: tb/tb_i2c_master.sv
// ----------------------------------------------------------------------------
// tb_i2c_master
// Drives i2c_master through an open-drain bus (wired AND of master and slave)
// with a behavioural slave, and compares against a transaction-level model.
// ----------------------------------------------------------------------------
module tb_i2c_master;

   localparam int CLK_DIV       = 4;
   localparam int PHASE_CYCLES  = 4 * CLK_DIV;
   localparam int STRETCH_PULL  = 65;
   localparam int STRETCH_FREE  = 123;
   localparam int STRETCH_EXTRA = 50;

   logic       clk = 1'b0;
   logic       nReset = 1'b0;
   logic       start = 1'b0;
   logic       rw = 1'b0;
   logic [6:0] addr = 7'h00;
   logic [7:0] wdata = 8'h00;
   logic       sclT, sdaT, busy, done, nack;
   logic [7:0] rdata;

   logic slvSclT = 1'b1;
   logic slvSdaT = 1'b1;
   logic sclBus, sdaBus;
   assign sclBus = sclT & slvSclT;
   assign sdaBus = sdaT & slvSdaT;

   logic [6:0] slvAddr = 7'h00;
   logic       slvPresent = 1'b0;
   logic       slvDataAck = 1'b1;
   logic [7:0] slvRdByte = 8'h00;
   logic [7:0] slvAddrByte = 8'h00;
   int         slvBit = 0;
   logic       prevScl = 1'b1;
   logic       prevSda = 1'b1;
   logic       sdaLog[$];

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   i2c_master #(.CLK_DIV(CLK_DIV)) dut (
      .I_CLK(clk), .I_NRESET(nReset), .I_START(start), .I_RW(rw),
      .I_ADDR(addr), .I_WDATA(wdata), .I_SCL(sclBus), .I_SDA(sdaBus),
      .O_SCL_T(sclT), .O_SDA_T(sdaT), .O_BUSY(busy), .O_DONE(done),
      .O_RDATA(rdata), .O_NACK(nack)
   );

   // Behavioural slave: logs SDA on every SCL rise, changes SDA only on SCL fall.
   always @(sclBus or sdaBus) begin
      if (sclBus !== prevScl) begin
         if (sclBus === 1'b1) begin
            slvBit++;
            if (slvBit <= 18) sdaLog.push_back(sdaBus);
            if (slvBit <= 8) slvAddrByte = {slvAddrByte[6:0], sdaBus};
         end else begin
            slvSdaT = 1'b1;
            if (slvPresent && (slvAddrByte[7:1] == slvAddr)) begin
               if (slvBit == 8) slvSdaT = 1'b0;
               else if (slvAddrByte[0] && slvBit >= 9 && slvBit <= 16) slvSdaT = slvRdByte[16 - slvBit];
               else if (!slvAddrByte[0] && slvBit == 17 && slvDataAck) slvSdaT = 1'b0;
            end
         end
      end else if (sclBus === 1'b1 && sdaBus === 1'b0 && prevSda === 1'b1) begin
         slvBit = 0;
         sdaLog.delete();
      end
      prevScl = sclBus;
      prevSda = sdaT & slvSdaT;
   end

   // Transaction-level expectations: phases of 4 quarters, 11 on address NACK, 20 otherwise.
   function automatic void model(input logic rwIn, input logic [6:0] addrIn, input logic [7:0] wdataIn,
                                 input int extra, output int expCycles, output logic expNack,
                                 output logic [17:0] expBits, output logic [17:0] mask);
      logic addrAck;
      logic [7:0] dataByte;
      logic lastBit;
      addrAck   = slvPresent && (addrIn == slvAddr);
      dataByte  = rwIn ? slvRdByte : wdataIn;
      lastBit   = rwIn ? 1'b1 : ~slvDataAck;
      expNack   = !addrAck || (!rwIn && !slvDataAck);
      expCycles = (addrAck ? 20 : 11) * PHASE_CYCLES + extra;
      expBits   = {addrIn, rwIn, ~addrAck, dataByte, lastBit};
      mask      = addrAck ? 18'h3FFFF : 18'h3FE00;
   endfunction

   task automatic runCmd(input logic rwIn, input logic [6:0] addrIn, input logic [7:0] wdataIn,
                         input bit stretch, input bit pulseMid, input int resetAt,
                         output int cycles, output logic [17:0] bits, output logic busyEarly);
      cycles = -1;
      rw = rwIn; addr = addrIn; wdata = wdataIn; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      busyEarly = busy;
      for (int cyc = 1; cyc <= 2000; cyc++) begin
         @(posedge clk); #1;
         if (stretch && cyc == STRETCH_PULL) slvSclT = 1'b0;
         if (stretch && cyc == STRETCH_FREE) slvSclT = 1'b1;
         if (pulseMid && cyc == 100) begin
            rw = ~rwIn; addr = ~addrIn; wdata = ~wdataIn; start = 1'b1;
         end
         if (pulseMid && cyc == 101) start = 1'b0;
         if (resetAt != 0 && cyc == resetAt) begin
            nReset = 1'b0;
            break;
         end
         if (done === 1'b1) begin
            cycles = cyc;
            break;
         end
      end
      bits = 'x;
      for (int i = 0; i < 18 && i < sdaLog.size(); i++) bits[17 - i] = sdaLog[i];
   endtask

   task automatic test_reset();
      nReset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (sclT !== 1'b1) begin fails++; $display("[TB] FAIL reset_scl: got %b expected 1", sclT); end
      checks++; if (sdaT !== 1'b1) begin fails++; $display("[TB] FAIL reset_sda: got %b expected 1", sdaT); end
      checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
      checks++; if (nack !== 1'b0) begin fails++; $display("[TB] FAIL reset_nack: got %b expected 0", nack); end
      checks++; if (rdata !== 8'h00) begin fails++; $display("[TB] FAIL reset_rdata: got %h expected 00", rdata); end
      @(negedge clk); nReset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_write_ack();
      int cyc, expCyc; logic [17:0] bits, expBits, mask; logic be, expNack;
      slvPresent = 1'b1; slvAddr = 7'h50; slvDataAck = 1'b1;
      runCmd(1'b0, 7'h50, 8'hA5, 1'b0, 1'b0, 0, cyc, bits, be);
      model(1'b0, 7'h50, 8'hA5, 0, expCyc, expNack, expBits, mask);
      checks++; if (be !== 1'b1) begin fails++; $display("[TB] FAIL write_busy_rise: got %b expected 1", be); end
      checks++; if (cyc !== expCyc) begin fails++; $display("[TB] FAIL write_done_cycles: got %0d expected %0d", cyc, expCyc); end
      checks++; if (nack !== expNack) begin fails++; $display("[TB] FAIL write_nack: got %b expected %b", nack, expNack); end
      checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL write_busy_fall: got %b expected 0", busy); end
      checks++; if ((bits & mask) !== (expBits & mask)) begin fails++; $display("[TB] FAIL write_sda_bits: got %b expected %b", bits, expBits); end
   endtask

   task automatic test_addr_nack();
      int cyc, expCyc; logic [17:0] bits, expBits, mask; logic be, expNack;
      slvPresent = 1'b0;
      runCmd(1'b0, 7'h21, 8'h3C, 1'b0, 1'b0, 0, cyc, bits, be);
      model(1'b0, 7'h21, 8'h3C, 0, expCyc, expNack, expBits, mask);
      checks++; if (cyc !== expCyc) begin fails++; $display("[TB] FAIL nack_done_cycles: got %0d expected %0d", cyc, expCyc); end
      checks++; if (nack !== expNack) begin fails++; $display("[TB] FAIL nack_flag: got %b expected %b", nack, expNack); end
      checks++; if ((bits & mask) !== (expBits & mask)) begin fails++; $display("[TB] FAIL nack_sda_bits: got %b expected %b", bits, expBits); end
   endtask

   task automatic test_read();
      int cyc, expCyc; logic [17:0] bits, expBits, mask; logic be, expNack;
      slvPresent = 1'b1; slvAddr = 7'h3C; slvRdByte = 8'h96;
      runCmd(1'b1, 7'h3C, 8'h00, 1'b0, 1'b0, 0, cyc, bits, be);
      model(1'b1, 7'h3C, 8'h00, 0, expCyc, expNack, expBits, mask);
      checks++; if (rdata !== slvRdByte) begin fails++; $display("[TB] FAIL read_rdata: got %h expected %h", rdata, slvRdByte); end
      checks++; if (nack !== expNack) begin fails++; $display("[TB] FAIL read_nack: got %b expected %b", nack, expNack); end
      checks++; if (cyc !== expCyc) begin fails++; $display("[TB] FAIL read_done_cycles: got %0d expected %0d", cyc, expCyc); end
      checks++; if ((bits & mask) !== (expBits & mask)) begin fails++; $display("[TB] FAIL read_sda_bits: got %b expected %b", bits, expBits); end
   endtask

   task automatic test_stretch();
      int cyc, expCyc; logic [17:0] bits, expBits, mask; logic be, expNack;
      slvPresent = 1'b1; slvAddr = 7'h50; slvDataAck = 1'b1;
      runCmd(1'b0, 7'h50, 8'h5A, 1'b1, 1'b0, 0, cyc, bits, be);
      model(1'b0, 7'h50, 8'h5A, STRETCH_EXTRA, expCyc, expNack, expBits, mask);
      checks++; if (cyc !== expCyc) begin fails++; $display("[TB] FAIL stretch_done_cycles: got %0d expected %0d", cyc, expCyc); end
      checks++; if (nack !== expNack) begin fails++; $display("[TB] FAIL stretch_nack: got %b expected %b", nack, expNack); end
      checks++; if ((bits & mask) !== (expBits & mask)) begin fails++; $display("[TB] FAIL stretch_sda_bits: got %b expected %b", bits, expBits); end
   endtask

   task automatic test_ignore_and_reset();
      int cyc, expCyc; logic [17:0] bits, expBits, mask; logic be, expNack;
      slvPresent = 1'b1; slvAddr = 7'h50; slvDataAck = 1'b1;
      runCmd(1'b0, 7'h50, 8'hC3, 1'b0, 1'b1, 0, cyc, bits, be);
      model(1'b0, 7'h50, 8'hC3, 0, expCyc, expNack, expBits, mask);
      checks++; if (cyc !== expCyc) begin fails++; $display("[TB] FAIL ignore_done_cycles: got %0d expected %0d", cyc, expCyc); end
      checks++; if ((bits & mask) !== (expBits & mask)) begin fails++; $display("[TB] FAIL ignore_sda_bits: got %b expected %b", bits, expBits); end
      // Reset during data bit 4 (phase 14 from the accept edge).
      runCmd(1'b0, 7'h50, 8'h0F, 1'b0, 1'b0, 14 * PHASE_CYCLES + 2, cyc, bits, be);
      #1;
      checks++; if (sclT !== 1'b1) begin fails++; $display("[TB] FAIL midreset_scl: got %b expected 1", sclT); end
      checks++; if (sdaT !== 1'b1) begin fails++; $display("[TB] FAIL midreset_sda: got %b expected 1", sdaT); end
      checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
      @(negedge clk); nReset = 1'b1;
      @(posedge clk); #1;
      slvAddr = 7'h3C; slvRdByte = 8'h69;
      runCmd(1'b1, 7'h3C, 8'h00, 1'b0, 1'b0, 0, cyc, bits, be);
      model(1'b1, 7'h3C, 8'h00, 0, expCyc, expNack, expBits, mask);
      checks++; if (cyc !== expCyc) begin fails++; $display("[TB] FAIL after_reset_cycles: got %0d expected %0d", cyc, expCyc); end
      checks++; if (rdata !== slvRdByte) begin fails++; $display("[TB] FAIL after_reset_rdata: got %h expected %h", rdata, slvRdByte); end
   endtask

   // Random commands issued back to back: each starts the cycle after O_DONE.
   task automatic test_back_to_back_random();
      int cyc, expCyc; logic [17:0] bits, expBits, mask; logic be, expNack;
      logic rRw; logic [6:0] rAddr; logic [7:0] rData;
      for (int n = 0; n < 12; n++) begin
         rRw = 1'($urandom_range(0, 1)); rAddr = 7'($urandom); rData = 8'($urandom);
         slvAddr = rAddr; slvPresent = ($urandom_range(0, 3) != 0);
         slvDataAck = ($urandom_range(0, 3) != 0); slvRdByte = 8'($urandom);
         runCmd(rRw, rAddr, rData, 1'b0, 1'b0, 0, cyc, bits, be);
         model(rRw, rAddr, rData, 0, expCyc, expNack, expBits, mask);
         checks++; if (cyc !== expCyc) begin fails++; $display("[TB] FAIL rand%0d_cycles: got %0d expected %0d", n, cyc, expCyc); end
         checks++; if (nack !== expNack) begin fails++; $display("[TB] FAIL rand%0d_nack: got %b expected %b", n, nack, expNack); end
         checks++; if ((bits & mask) !== (expBits & mask)) begin fails++; $display("[TB] FAIL rand%0d_sda_bits: got %b expected %b", n, bits, expBits); end
         if (rRw && !expNack) begin
            checks++; if (rdata !== slvRdByte) begin fails++; $display("[TB] FAIL rand%0d_rdata: got %h expected %h", n, rdata, slvRdByte); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_ack();
      test_addr_nack();
      test_read();
      test_stretch();
      test_ignore_and_reset();
      test_back_to_back_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
